// File: rtl/lif_layer_tm.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons: one shared
// accumulate/leak/threshold datapath sweeps every neuron once per input timestep.
module lif_layer_tm #(
  parameter int SYNAPSES       = 32,
  parameter int NEURONS        = 8,
  parameter int NIDX           = $clog2(NEURONS),
  parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
  parameter int REFRAC_BITS    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_we,
  input  logic [NIDX-1:0]                  w_addr,
  input  logic [SYNAPSES-1:0]              w_data,
  input  logic [2:0]                       shift,
  input  logic [THRESHOLD_BITS-1:0]        threshold,
  input  logic                             reset_mode,
  input  logic [REFRAC_BITS-1:0]           refractory,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SYNAPSES-1:0]              in_spikes,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NEURONS-1:0]               out_spikes,
  output logic                             mem_valid,
  output logic [NIDX-1:0]                  mem_idx,
  output logic signed [MEMBRANE_BITS-1:0]  mem_value,
  output logic [1:0]                       fsm_state
);
  localparam int M  = MEMBRANE_BITS;
  localparam int CW = $clog2(SYNAPSES + 1);
  localparam int AW = M + 2;
  localparam logic [NIDX-1:0] LAST = NIDX'(NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [NIDX-1:0]          idx;
  logic [SYNAPSES-1:0]      x_q;
  logic [2:0]               shift_q;
  logic [THRESHOLD_BITS-1:0] thr_q;
  logic                     mode_q;
  logic [REFRAC_BITS-1:0]   refr_q;

  logic [SYNAPSES-1:0]      w_mem [NEURONS];
  logic signed [M-1:0]      u_mem [NEURONS];
  logic [REFRAC_BITS-1:0]   r_mem [NEURONS];

  logic [SYNAPSES-1:0]      row;
  logic [CW-1:0]            cnt_hit;
  logic [CW-1:0]            cnt_all;
  logic signed [AW-1:0]     hit_w;
  logic signed [AW-1:0]     all_w;
  logic signed [AW-1:0]     psp;
  logic signed [M-1:0]      u_cur;
  logic signed [M-1:0]      u_shr;
  logic signed [M-1:0]      d;
  logic signed [AW-1:0]     d_w;
  logic signed [AW-1:0]     sum;
  logic signed [M-1:0]      a;
  logic signed [M-1:0]      thr_ext;
  logic [REFRAC_BITS-1:0]   r_cur;
  logic                     refr_busy;
  logic                     spike;
  logic signed [M-1:0]      u_new;
  logic [REFRAC_BITS-1:0]   r_new;

  function automatic logic [CW-1:0] popcount(input logic [SYNAPSES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < SYNAPSES; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is only high in IDLE (and never during reset); out_valid
  // holds with stable out_spikes until out_ready is seen.
  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = (state == S_DONE);
  assign mem_valid = (state == S_RUN);
  assign mem_idx   = idx;
  assign mem_value = u_new;
  assign fsm_state = state;

  always_comb begin
    row       = w_mem[idx];
    u_cur     = u_mem[idx];
    r_cur     = r_mem[idx];
    refr_busy = (r_cur != '0);
    cnt_hit   = popcount(x_q & row);
    cnt_all   = popcount(x_q);
    hit_w     = AW'(cnt_hit);
    all_w     = AW'(cnt_all);
    psp       = refr_busy ? '0 : ((hit_w <<< 1) - all_w);
    u_shr     = u_cur >>> shift_q;
    d         = (shift_q == 3'd0) ? u_cur : (u_cur - u_shr);
    d_w       = {{(AW-M){d[M-1]}}, d};
    sum       = d_w + psp;
    // Clamp when the upper bits are not a pure sign extension.
    if ((sum[AW-1:M-1] == '0) || (sum[AW-1:M-1] == '1)) a = sum[M-1:0];
    else if (sum[AW-1])                                    a = {1'b1, {(M-1){1'b0}}};
    else                                                   a = {1'b0, {(M-1){1'b1}}};
    thr_ext   = $signed({1'b0, thr_q});
    spike     = !refr_busy && (a >= thr_ext);
    if (spike) begin
      u_new = mode_q ? (a - thr_ext) : '0;
      r_new = refr_q;
    end else begin
      u_new = a;
      r_new = refr_busy ? (r_cur - REFRAC_BITS'(1)) : r_cur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NEURONS; n++) w_mem[n] <= '0;
    end else if (w_we) begin
      w_mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      x_q        <= '0;
      shift_q    <= '0;
      thr_q      <= '0;
      mode_q     <= 1'b0;
      refr_q     <= '0;
      out_spikes <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        u_mem[n] <= '0;
        r_mem[n] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q     <= in_spikes;
            shift_q <= shift;
            thr_q   <= threshold;
            mode_q  <= reset_mode;
            refr_q  <= refractory;
            idx     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          u_mem[idx]      <= u_new;
          r_mem[idx]      <= r_new;
          out_spikes[idx] <= spike;
          if (idx == LAST) state <= S_DONE;
          else             idx   <= idx + NIDX'(1);
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_layer_tm.sv
// Scoreboarded bench for lif_layer_tm: an integer reference model predicts the
// membrane debug stream and output spike vectors of every timestep.
module tb_lif_layer_tm;
  localparam int S = 32;
  localparam int N = 8;
  localparam int NI = 3;
  localparam int M = 7;
  localparam int TB = 6;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_we = 1'b0;
  logic [NI-1:0] w_addr = '0;
  logic [S-1:0] w_data = '0;
  logic [2:0] shift = '0;
  logic [TB-1:0] threshold = '0;
  logic reset_mode = 1'b0;
  logic [RB-1:0] refractory = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [S-1:0] in_spikes = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [N-1:0] out_spikes;
  logic mem_valid;
  logic [NI-1:0] mem_idx;
  logic signed [M-1:0] mem_value;
  logic [1:0] fsm_state;

  lif_layer_tm dut (
    .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .shift(shift), .threshold(threshold), .reset_mode(reset_mode),
    .refractory(refractory), .in_valid(in_valid), .in_ready(in_ready),
    .in_spikes(in_spikes), .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .mem_valid(mem_valid), .mem_idx(mem_idx),
    .mem_value(mem_value), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [NI+M-1:0] exp_mem_q[$];
  logic [N-1:0]    exp_out_q[$];
  int seen_u [N];
  logic [N-1:0] seen_out;

  // Reference model state
  logic [S-1:0] m_w [N];
  int m_u [N];
  int m_r [N];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < N; n++) begin
      m_w[n] = '0; m_u[n] = 0; m_r[n] = 0;
    end
  endtask

  task automatic model_step(input logic [S-1:0] x, input int sh, input int thr,
                            input int mode, input int refr);
    logic [N-1:0] spikes;
    logic [M-1:0] uv;
    spikes = '0;
    for (int n = 0; n < N; n++) begin
      int psp, d, a;
      psp = 2 * $countones(x & m_w[n]) - $countones(x);
      if (m_r[n] > 0) psp = 0;
      d = (sh == 0) ? m_u[n] : m_u[n] - (m_u[n] >>> sh);
      a = d + psp;
      if (a > 63) a = 63;
      if (a < -64) a = -64;
      if (m_r[n] == 0 && a >= thr) begin
        spikes[n] = 1'b1;
        m_u[n] = (mode != 0) ? a - thr : 0;
        m_r[n] = refr;
      end else begin
        m_u[n] = a;
        if (m_r[n] > 0) m_r[n] = m_r[n] - 1;
      end
      uv = M'(m_u[n]);
      exp_mem_q.push_back({NI'(n), uv});
    end
    exp_out_q.push_back(spikes);
  endtask

  // Monitor: pops and compares whenever the DUT presents an output.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        seen_u[mem_idx] = int'(mem_value);
        if (exp_mem_q.size() == 0) begin
          check("mem_unexpected", 1, 0);
        end else begin
          logic [NI+M-1:0] e;
          e = exp_mem_q.pop_front();
          check("mem_idx", int'(mem_idx), int'(e[NI+M-1:M]));
          check("mem_value", int'(mem_value), int'($signed(e[M-1:0])));
        end
      end
      if (out_valid && out_ready) begin
        seen_out = out_spikes;
        if (exp_out_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          check("out_spikes", int'(out_spikes), int'(exp_out_q.pop_front()));
        end
      end
    end
  end

  task automatic write_row(input int row, input logic [S-1:0] data);
    w_we = 1'b1; w_addr = NI'(row); w_data = data;
    @(posedge clk); #1;
    w_we = 1'b0;
    m_w[row] = data;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mem_valid", int'(mem_valid), 0);
    check("rst_out_spikes", int'(out_spikes), 0);
    exp_mem_q.delete();
    exp_out_q.delete();
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  // Issue one timestep, then optionally stall out_ready for 'hold' cycles.
  task automatic run_step(input logic [S-1:0] x, input int sh, input int thr,
                          input int mode, input int refr, input int hold);
    int n;
    in_spikes = x; shift = 3'(sh); threshold = TB'(thr);
    reset_mode = mode[0]; refractory = RB'(refr);
    in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_step(x, sh, thr, mode, refr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Late changes must not affect the timestep already accepted.
    shift = 3'($urandom_range(0, 7));
    threshold = TB'($urandom_range(0, 63));
    reset_mode = 1'($urandom_range(0, 1));
    refractory = RB'($urandom_range(0, 3));
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("out_timeout", 0, 1);
      return;
    end
    if (hold > 0) begin
      logic [N-1:0] held;
      held = out_spikes;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_out_spikes", int'(out_spikes), int'(held));
        check("hold_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [S-1:0] x;
    int n;
    model_clear();
    @(posedge clk); #1;
    apply_reset();

    // Integrate and fire
    write_row(0, '1);
    run_step(32'h0000000F, 0, 10, 0, 0, 0);
    check("if_u0_1", seen_u[0], 4);
    check("if_u1_1", seen_u[1], -4);
    check("if_out_1", int'(seen_out), 0);
    run_step(32'h0000000F, 0, 10, 0, 0, 0);
    check("if_u0_2", seen_u[0], 8);
    check("if_u7_2", seen_u[7], -8);
    check("if_out_2", int'(seen_out), 0);
    run_step(32'h0000000F, 0, 10, 0, 0, 0);
    check("if_u0_3", seen_u[0], 0);
    check("if_u3_3", seen_u[3], -12);
    check("if_out_3", int'(seen_out), 1);

    // Saturation
    apply_reset();
    run_step('1, 0, 10, 0, 0, 0);
    check("sat_u1_1", seen_u[1], -32);
    run_step('1, 0, 10, 0, 0, 0);
    check("sat_u1_2", seen_u[1], -64);
    run_step('1, 0, 10, 0, 0, 0);
    check("sat_u1_3", seen_u[1], -64);

    // Leak: neuron0 starts at 12, neuron1 at -8
    apply_reset();
    write_row(0, '1);
    write_row(1, 32'h00000003);
    run_step(32'h00000FFF, 0, 63, 0, 0, 0);
    check("leak_start0", seen_u[0], 12);
    check("leak_start1", seen_u[1], -8);
    begin
      int exp0 [5] = '{6, 3, 2, 1, 1};
      int exp1 [5] = '{-4, -2, -1, 0, 0};
      for (int i = 0; i < 5; i++) begin
        run_step('0, 1, 63, 0, 0, 0);
        check("leak_u0", seen_u[0], exp0[i]);
        check("leak_u1", seen_u[1], exp1[i]);
      end
    end

    // Subtract mode with refractory
    apply_reset();
    write_row(2, '1);
    begin
      int expu [4] = '{2, 2, 2, 4};
      int expb [4] = '{1, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
        run_step(32'h00000FFF, 0, 10, 1, 2, 0);
        check("sub_u2", seen_u[2], expu[i]);
        check("sub_bit2", int'(seen_out[2]), expb[i]);
      end
    end

    // Handshake and latency with a stalled consumer
    apply_reset();
    write_row(4, 32'hFFFF0000);
    x = $urandom;
    in_spikes = x; shift = 3'd0; threshold = TB'(3); reset_mode = 1'b0;
    refractory = '0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("hs_in_ready", int'(in_ready), 1);
    model_step(x, 0, 3, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("lat_mem_valid", int'(mem_valid), 1);
      check("lat_mem_idx", int'(mem_idx), k);
      check("lat_in_ready", int'(in_ready), 0);
      check("lat_out_valid", int'(out_valid), 0);
    end
    @(negedge clk);
    check("lat_out_valid_9", int'(out_valid), 1);
    begin
      logic [N-1:0] held;
      held = out_spikes;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        in_valid = (i == 2);
        @(negedge clk);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_out_spikes", int'(out_spikes), int'(held));
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_mem_valid", int'(mem_valid), 0);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("hs_in_ready_after", int'(in_ready), 1);
    check("hs_out_valid_after", int'(out_valid), 0);
    check("hs_queue_empty", exp_out_q.size(), 0);
    @(posedge clk); #1;

    // Randomized timesteps with weight updates between them
    apply_reset();
    for (int r = 0; r < N; r++) write_row(r, $urandom);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) write_row($urandom_range(0, N-1), $urandom);
      x = $urandom;
      if ($urandom_range(0, 3) == 0) x = x & 32'h000000FF;
      run_step(x, $urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a sweep
    x = $urandom | 32'h1;
    in_spikes = x; shift = '0; threshold = TB'(5); reset_mode = 1'b0;
    refractory = '0; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    model_step(x, 0, 5, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mem_valid && mem_idx == 3'd3) && n < 50) begin @(negedge clk); n++; end
    check("ar_reached_idx3", int'(mem_idx), 3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", int'(out_valid), 0);
    check("ar_mem_valid", int'(mem_valid), 0);
    check("ar_in_ready", int'(in_ready), 0);
    exp_mem_q.delete();
    exp_out_q.delete();
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ar_post_in_ready", int'(in_ready), 1);
    check("ar_post_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    x = $urandom | 32'h80000001;
    run_step(x, 0, 5, 0, 0, 0);
    for (int k = 0; k < N; k++) check("ar_zero_w_u", seen_u[k], -$countones(x));
    check("ar_zero_w_out", int'(seen_out), 0);

    repeat (3) @(posedge clk);
    check("final_mem_q_empty", exp_mem_q.size(), 0);
    check("final_out_q_empty", exp_out_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
